adat_frame_deserializer: RTL and testbench
==========================================

# adat_frame_deserializer

Upstream neighbour of the I2S MSB-justified transmitter. It consumes decoded ADAT bits and writes each 256-bit frame into the shared circular `channel_buffer` in I2S layout: 8 channels × 32-bit slots, 24 data bits MSB-first, then 8 zero pad bits. It publishes the index of the last complete, error-free frame and the resync request that the transmitter uses to restart its read pointer.

## Interface
Parameters:
- `CIRC_BUF_BITS`, 3, log2 of the number of frames in the circular buffer (RAM depth = 256 × 2^CIRC_BUF_BITS bits).
- `BAD_FRAME_LIMIT`, 2, number of consecutive bad frames that forces resync.
- `GOOD_FRAME_LIMIT`, 4, number of consecutive good frames that releases resync.

Ports:
- `clk_x4_i`  in  1  single clock (4× ADAT bit rate).
- `rst_n_i`  in  1  synchronous, active-low reset.
- `bit_valid_i`  in  1  one-cycle strobe, one per ADAT bit; strobes are spaced ≥4 cycles apart.
- `bit_i`  in  1  bit value, qualified by `bit_valid_i`.
- `sync_i`  in  1  asserted with `bit_valid_i` on the '1' that ends the 10-zero sync run (frame bit 10).
- `lock_i`  in  1  upstream decoder is locked.
- `ram_write_addr_o`  out  CIRC_BUF_BITS+8  RAM bit address.
- `ram_write_data_o`  out  1  RAM bit value.
- `ram_wr_en_o`  out  1  RAM write enable.
- `last_good_frame_idx_o`  out  CIRC_BUF_BITS  index of the last committed frame.
- `resync_req_o`  out  1  high = transmitter must resynchronise.
- `frame_error_o`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- FSM states:
  - HUNT: entered on reset and whenever `lock_i`=0. No writes. Moves to RECEIVE on `sync_i`&`bit_valid_i`&`lock_i`, with bit counter set to 10.
  - RECEIVE: the bit counter (8 bits) increments on each `bit_valid_i` and wraps 255→0.
- Frame bit map:
  - 11–14: user bits, discarded.
  - 15: separator.
  - Channel c occupies bits 16+30c … 45+30c as 6 groups of 4 data bits followed by 1 separator.
- Data bit k (0–23) of channel c is written to address `wr_frame*256 + c*32 + k`.
- After a channel's 24th data bit, 8 pad writes (positions 24–31, data 0) become pending. A pad write issues only on cycles without `bit_valid_i`, so a data write and a pad write never collide.
- Any separator bit = 0 marks the current frame bad. Writing continues, but that frame is not committed.
- `sync_i` while the counter ≠ 10 ends the frame as bad:
  - `frame_error_o` pulses.
  - Pending pads are cancelled.
  - The counter is set to 10 and a new frame starts at the same `wr_frame`.
- Commit point: bit 255 has been accepted and pending pads = 0. Then:
  - Good frame: `last_good_frame_idx_o` ← `wr_frame`; `wr_frame` ← `wr_frame`+1 (mod 2^CIRC_BUF_BITS); good-frame count increments; bad-frame count clears.
  - Bad frame: `frame_error_o` pulses; `wr_frame` is unchanged, so the frame is overwritten; bad-frame count increments; good-frame count clears.
- `resync_req_o`:
  - Set on reset, on `lock_i`=0, and when the bad-frame count reaches `BAD_FRAME_LIMIT`.
  - Cleared on the commit that brings the good-frame count to `GOOD_FRAME_LIMIT`.
  - Both frame counters saturate.
- `lock_i` falling mid-frame: go to HUNT; drop pending pads; `wr_frame` and `last_good_frame_idx_o` hold their values.

## Timing
- All outputs are registered.
- Reset values: address 0, data 0, `ram_wr_en_o` 0, `last_good_frame_idx_o` 0, `resync_req_o` 1, `frame_error_o` 0. Internal `wr_frame` is 0.
- Data write latency: `ram_wr_en_o`/address/data appear 1 cycle after the accepting `bit_valid_i`.
- Pad writes: one per free cycle, in ascending address order.
- Commit: `last_good_frame_idx_o` and `resync_req_o` update 1 cycle after the commit condition is met, which is at most 9 cycles after bit 255.
- `lock_i`=0: `ram_wr_en_o` is 0 from the next cycle; `resync_req_o` is 1 on the next cycle.
- Simultaneous sync error and commit cannot occur, because commit happens at counter 255/0 and sync is expected at counter 10.

## Test plan
- Reset held 3 cycles → all outputs at their reset values, `resync_req_o`=1, no writes.
- Four clean frames, channel c carrying 24'hA5C3F0+c → RAM[c*32 +: 24] holds that sample MSB-first with zeros at 24–31; `last_good_frame_idx_o` steps 0,1,2,3; `resync_req_o` falls after the 4th commit.
- Frame 5 with the channel-3 separator forced to 0 → one `frame_error_o` pulse, `last_good_frame_idx_o` stays 4, the next good frame is written at index 5 and commits as 5.
- `sync_i` at counter 100 → `frame_error_o` pulse, no commit, reception restarts at bit 11 in the same frame slot.
- Two consecutive bad frames after lock → `resync_req_o`=1; four good frames then clear it.
- `lock_i` dropped mid-channel-2 → `ram_wr_en_o`=0 the next cycle, `resync_req_o`=1, HUNT until the next `sync_i`.
- Nine good frames → `last_good_frame_idx_o` wraps 7→0; the 9th frame overwrites the addresses of frame 0.

Source files
------------

// File: rtl/adat_frame_deserializer.sv
// rtl/adat_frame_deserializer.sv - ADAT frame to circular I2S-layout bit buffer writer
//
// Purpose: accepts decoded ADAT bits, writes each 256-bit frame into a circular
// bit-addressed RAM as 8 x 32-bit slots (24 data bits MSB-first + 8 zero pads),
// commits error-free frames and drives the transmitter resync request.
//
// Ports:
//   clk_x4_i              clock, 4x the ADAT bit rate
//   rst_n_i               synchronous active-low reset
//   bit_valid_i           one-cycle strobe per decoded bit
//   bit_i                 bit value, qualified by bit_valid_i
//   sync_i                marks frame bit 10 (end of the sync run)
//   lock_i                upstream decoder locked
//   ram_write_addr_o      RAM bit address {frame, channel, bit}
//   ram_write_data_o      RAM bit value
//   ram_wr_en_o           RAM write enable
//   last_good_frame_idx_o index of the last committed frame
//   resync_req_o          transmitter must resynchronise
//   frame_error_o         one-cycle pulse when a frame is discarded
module adat_frame_deserializer #(
  parameter int CIRC_BUF_BITS    = 3,
  parameter int BAD_FRAME_LIMIT  = 2,
  parameter int GOOD_FRAME_LIMIT = 4
) (
  input  logic                       clk_x4_i,
  input  logic                       rst_n_i,
  input  logic                       bit_valid_i,
  input  logic                       bit_i,
  input  logic                       sync_i,
  input  logic                       lock_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
  output logic                       ram_write_data_o,
  output logic                       ram_wr_en_o,
  output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
  output logic                       resync_req_o,
  output logic                       frame_error_o
);

  localparam logic [7:0] BAD_LIM  = 8'(BAD_FRAME_LIMIT);
  localparam logic [7:0] GOOD_LIM = 8'(GOOD_FRAME_LIMIT);
  localparam logic [CIRC_BUF_BITS-1:0] FRAME_ONE = CIRC_BUF_BITS'(1);

  typedef enum logic {ST_HUNT, ST_RECEIVE} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [7:0]                  r_bit_cnt;
  logic [CIRC_BUF_BITS-1:0]    r_wr_frame;
  logic [3:0]                  r_pad_cnt;
  logic [2:0]                  r_pad_idx;
  logic [2:0]                  r_pad_chan;
  logic                        r_frame_bad;
  logic                        r_commit_pend;
  logic [7:0]                  r_good_cnt;
  logic [7:0]                  r_bad_cnt;

  logic [7:0] w_idx, w_off, w_rem;
  logic [2:0] w_chan, w_grp, w_pos;
  logic [4:0] w_k;
  logic       w_in_chan, w_is_sep, w_is_data;
  logic       w_accept, w_sync_err, w_data_wr, w_pad_wr, w_commit;
  logic [7:0] w_good_inc, w_bad_inc;

  // r_bit_cnt holds the index of the last accepted bit, so the incoming
  // bit is r_bit_cnt+1 (wrapping 255 -> 0 between frames).
  always_comb begin
    w_idx     = r_bit_cnt + 8'd1;
    w_off     = w_idx - 8'd16;
    w_in_chan = (w_idx >= 8'd16);
    // Channel slot is 30 bits: 6 groups of 4 data bits + 1 separator.
    w_chan    = 3'(w_off / 8'd30);
    w_rem     = w_off - 8'(w_chan) * 8'd30;
    w_grp     = 3'(w_rem / 8'd5);
    w_pos     = 3'(w_rem - 8'(w_grp) * 8'd5);
    w_k       = {w_grp[2:0], 2'b00} + 5'(w_pos);
    w_is_sep  = (w_idx == 8'd15) || (w_in_chan && (w_pos == 3'd4));
    w_is_data = w_in_chan && (w_pos != 3'd4);

    w_accept   = bit_valid_i && lock_i && (r_state == ST_RECEIVE);
    w_sync_err = w_accept && sync_i && (w_idx != 8'd10);
    w_data_wr  = w_accept && !w_sync_err && w_is_data;
    // Pads only use strobe-free cycles so they never collide with data.
    w_pad_wr   = !bit_valid_i && lock_i && (r_state == ST_RECEIVE) && (r_pad_cnt != 4'd0);
    w_commit   = lock_i && (r_state == ST_RECEIVE) && r_commit_pend && (r_pad_cnt == 4'd0);

    w_good_inc = (r_good_cnt < GOOD_LIM) ? r_good_cnt + 8'd1 : r_good_cnt;
    w_bad_inc  = (r_bad_cnt < BAD_LIM) ? r_bad_cnt + 8'd1 : r_bad_cnt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!lock_i) begin
      w_state_nxt = ST_HUNT;
    end else if ((r_state == ST_HUNT) && bit_valid_i && sync_i) begin
      w_state_nxt = ST_RECEIVE;
    end
  end

  always_ff @(posedge clk_x4_i) begin
    if (!rst_n_i) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_x4_i) begin
    if (!rst_n_i) begin
      r_bit_cnt             <= 8'd0;
      r_wr_frame            <= '0;
      r_pad_cnt             <= 4'd0;
      r_pad_idx             <= 3'd0;
      r_pad_chan            <= 3'd0;
      r_frame_bad           <= 1'b0;
      r_commit_pend         <= 1'b0;
      r_good_cnt            <= 8'd0;
      r_bad_cnt             <= 8'd0;
      ram_write_addr_o      <= '0;
      ram_write_data_o      <= 1'b0;
      ram_wr_en_o           <= 1'b0;
      last_good_frame_idx_o <= '0;
      resync_req_o          <= 1'b1;
      frame_error_o         <= 1'b0;
    end else begin
      ram_wr_en_o   <= 1'b0;
      frame_error_o <= 1'b0;
      if (!lock_i) begin
        // wr_frame and the last committed index survive a lock loss.
        r_pad_cnt     <= 4'd0;
        r_commit_pend <= 1'b0;
        r_frame_bad   <= 1'b0;
        r_good_cnt    <= 8'd0;
        r_bad_cnt     <= 8'd0;
        resync_req_o  <= 1'b1;
      end else if (r_state == ST_HUNT) begin
        if (bit_valid_i && sync_i) begin
          r_bit_cnt     <= 8'd10;
          r_frame_bad   <= 1'b0;
          r_pad_cnt     <= 4'd0;
          r_commit_pend <= 1'b0;
        end
      end else if (w_sync_err) begin
        // Early sync: abandon this frame and restart in the same slot.
        frame_error_o <= 1'b1;
        r_pad_cnt     <= 4'd0;
        r_bit_cnt     <= 8'd10;
        r_frame_bad   <= 1'b0;
        r_commit_pend <= 1'b0;
        r_bad_cnt     <= w_bad_inc;
        r_good_cnt    <= 8'd0;
        if (w_bad_inc >= BAD_LIM) resync_req_o <= 1'b1;
      end else begin
        if (w_accept) r_bit_cnt <= w_idx;
        if (w_accept && w_is_sep && !bit_i) r_frame_bad <= 1'b1;
        if (w_accept && (w_idx == 8'd255)) r_commit_pend <= 1'b1;

        if (w_data_wr) begin
          ram_wr_en_o      <= 1'b1;
          ram_write_addr_o <= {r_wr_frame, w_chan, w_k};
          ram_write_data_o <= bit_i;
          if (w_k == 5'd23) begin
            r_pad_cnt  <= 4'd8;
            r_pad_idx  <= 3'd0;
            r_pad_chan <= w_chan;
          end
        end else if (w_pad_wr) begin
          ram_wr_en_o      <= 1'b1;
          ram_write_addr_o <= {r_wr_frame, r_pad_chan, 2'b11, r_pad_idx};
          ram_write_data_o <= 1'b0;
          r_pad_cnt        <= r_pad_cnt - 4'd1;
          r_pad_idx        <= r_pad_idx + 3'd1;
        end

        if (w_commit) begin
          r_commit_pend <= 1'b0;
          r_frame_bad   <= 1'b0;
          if (!r_frame_bad) begin
            last_good_frame_idx_o <= r_wr_frame;
            r_wr_frame            <= r_wr_frame + FRAME_ONE;
            r_good_cnt            <= w_good_inc;
            r_bad_cnt             <= 8'd0;
            if (w_good_inc >= GOOD_LIM) resync_req_o <= 1'b0;
          end else begin
            // Slot is reused, so the bad frame is simply overwritten.
            frame_error_o <= 1'b1;
            r_bad_cnt     <= w_bad_inc;
            r_good_cnt    <= 8'd0;
            if (w_bad_inc >= BAD_LIM) resync_req_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adat_frame_deserializer.sv
// tb/tb_adat_frame_deserializer.sv - self-checking bench for adat_frame_deserializer
module tb_adat_frame_deserializer;

  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_valid;
  logic          bit_in;
  logic          sync_in;
  logic          lock_in;
  logic [CB+7:0] wr_addr;
  logic          wr_data;
  logic          wr_en;
  logic [CB-1:0] last_idx;
  logic          resync;
  logic          frame_err;

  always #5 clk = ~clk;

  adat_frame_deserializer #(
    .CIRC_BUF_BITS(CB), .BAD_FRAME_LIMIT(2), .GOOD_FRAME_LIMIT(4)
  ) dut (
    .clk_x4_i(clk), .rst_n_i(rst_n), .bit_valid_i(bit_valid), .bit_i(bit_in),
    .sync_i(sync_in), .lock_i(lock_in), .ram_write_addr_o(wr_addr),
    .ram_write_data_o(wr_data), .ram_wr_en_o(wr_en),
    .last_good_frame_idx_o(last_idx), .resync_req_o(resync),
    .frame_error_o(frame_err)
  );

  typedef struct {
    int kind;      // 0 good, 1 separator error, 2 early sync then good frame
    int bad_ch;
    int exp_last;
    int exp_resync;
    int exp_err;
  } vec_t;

  vec_t tbl[14];
  int   n_vec = 0;
  int   n_err = 0;
  int   err_pulses = 0;
  int   dq[$];
  int   pq[$];
  logic fb[256];
  int   fk[256];
  int   fc[256];
  int   exp_wr = 0;
  int   mon_act;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
    if (wr_en === 1'b1) begin
      mon_act = int'({wr_addr, wr_data});
      if (wr_addr[4:3] == 2'b11) begin
        if (pq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_pad_write: got 0x%0h expected none", mon_act);
        end else chk("pad_write", mon_act, pq.pop_front());
      end else begin
        if (dq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_data_write: got 0x%0h expected none", mon_act);
        end else chk("data_write", mon_act, dq.pop_front());
      end
    end
  end

  task automatic build_frame(input int f, input int bad_ch);
    logic [23:0] s;
    for (int i = 0; i < 256; i++) begin
      fb[i] = 1'b0; fk[i] = -1; fc[i] = 0;
    end
    fb[10] = 1'b1;
    for (int i = 11; i < 15; i++) fb[i] = 1'($urandom_range(0, 1));
    fb[15] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s = 24'hA5C3F0 + 24'(c) + 24'(f) * 24'h010101;
      for (int g = 0; g < 6; g++) fb[16 + 30*c + 5*g + 4] = 1'b1;
      for (int k = 0; k < 24; k++) begin
        int p;
        p = 16 + 30*c + (k/4)*5 + (k%4);
        fb[p] = s[23-k];
        fk[p] = k;
        fc[p] = c;
      end
    end
    if (bad_ch >= 0) fb[16 + 30*bad_ch + 4] = 1'b0;
  endtask

  task automatic push_bit(input int i);
    if (fk[i] >= 0) begin
      dq.push_back(((exp_wr*256 + fc[i]*32 + fk[i]) << 1) | int'(fb[i]));
      if (fk[i] == 23)
        for (int p = 24; p < 32; p++) pq.push_back((exp_wr*256 + fc[i]*32 + p) << 1);
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = b; sync_in = s;
    @(negedge clk);
    bit_valid = 1'b0; sync_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      push_bit(i);
      send_bit(fb[i], logic'(i == 10));
    end
  endtask

  initial begin
    rst_n = 1'b0; lock_in = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sync_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_last", int'(last_idx), 0);
    chk("rst_resync", int'(resync), 1);
    chk("rst_frame_err", int'(frame_err), 0);

    tbl[0]  = '{0, -1, 0, 1, 0};
    tbl[1]  = '{0, -1, 1, 1, 0};
    tbl[2]  = '{0, -1, 2, 1, 0};
    tbl[3]  = '{0, -1, 3, 0, 0};
    tbl[4]  = '{0, -1, 4, 0, 0};
    tbl[5]  = '{1,  3, 4, 0, 1};
    tbl[6]  = '{0, -1, 5, 0, 0};
    tbl[7]  = '{2, -1, 6, 0, 1};
    tbl[8]  = '{1,  0, 6, 0, 1};
    tbl[9]  = '{1,  7, 6, 1, 1};
    tbl[10] = '{0, -1, 7, 1, 0};
    tbl[11] = '{0, -1, 0, 1, 0};
    tbl[12] = '{0, -1, 1, 1, 0};
    tbl[13] = '{0, -1, 2, 0, 0};

    rst_n = 1'b1; lock_in = 1'b1;
    for (int v = 0; v < 14; v++) begin
      int e0;
      e0 = err_pulses;
      if (tbl[v].kind == 2) begin
        build_frame(v, -1);
        send_range(0, 99);
        send_bit(1'b1, 1'b1);
        build_frame(v + 100, -1);
        send_range(11, 255);
      end else begin
        build_frame(v, (tbl[v].kind == 1) ? tbl[v].bad_ch : -1);
        send_range(0, 255);
      end
      if (tbl[v].kind != 1) exp_wr = (exp_wr + 1) % 8;
      repeat (12) @(negedge clk);
      chk($sformatf("v%0d_last_idx", v), int'(last_idx), tbl[v].exp_last);
      chk($sformatf("v%0d_resync", v), int'(resync), tbl[v].exp_resync);
      chk($sformatf("v%0d_err_pulses", v), err_pulses - e0, tbl[v].exp_err);
    end

    build_frame(50, -1);
    send_range(0, 83);
    push_bit(84);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = fb[84];
    @(negedge clk);
    bit_valid = 1'b0; lock_in = 1'b0;
    @(negedge clk);
    chk("lockloss_wr_en", int'(wr_en), 0);
    chk("lockloss_resync", int'(resync), 1);
    chk("lockloss_last_idx", int'(last_idx), 2);
    lock_in = 1'b1;
    for (int i = 0; i < 24; i++) send_bit(logic'(i % 3 == 0), 1'b0);
    chk("hunt_resync", int'(resync), 1);

    build_frame(60, -1);
    send_range(0, 255);
    exp_wr = (exp_wr + 1) % 8;
    repeat (12) @(negedge clk);
    chk("relock_last_idx", int'(last_idx), 3);
    chk("relock_resync", int'(resync), 1);
    chk("data_queue_drained", dq.size(), 0);
    chk("pad_queue_drained", pq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
